// File: rtl/data_memory_block_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_memory_block_responder
// Description : Block-refill main-memory responder for the data cache; one
//               16-byte block read or write per request, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_block_responder #(
    parameter int DEPTH_BLOCKS = 256,
    parameter int LATENCY      = 5
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         MEM_READ,
    input  logic         MEM_WRITE,
    input  logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_WRITEDATA,
    output logic [127:0] MEM_READDATA,
    output logic         MEM_BUSYWAIT,
    output logic         PROTOCOL_ERR
);

    localparam int c_AW = $clog2(DEPTH_BLOCKS);
    localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                               state_q;
    logic [c_CW-1:0]                      cnt_q;
    logic                                 is_write_q;
    logic [c_AW-1:0]                      idx_q;
    logic [127:0]                         wdata_q;
    logic [127:0]                         rdata_q;
    logic                                 perr_q;
    logic [DEPTH_BLOCKS-1:0][127:0]       mem_q;

    logic [c_AW-1:0]                      w_idx;
    logic                                 w_req_any;
    logic                                 w_req_both;

    // Upper address bits alias onto the same storage and are deliberately dropped.
    assign w_idx      = MEM_ADDRESS[c_AW-1:0];
    assign w_req_any  = MEM_READ | MEM_WRITE;
    assign w_req_both = MEM_READ & MEM_WRITE;

    generate
        if (c_AW < 28) begin : g_addr_unused
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^MEM_ADDRESS[27:c_AW];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            perr_q     <= 1'b0;
            mem_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req_both) begin
                        perr_q <= 1'b1;
                    end else if (w_req_any) begin
                        is_write_q <= MEM_WRITE;
                        idx_q      <= w_idx;
                        wdata_q    <= MEM_WRITEDATA;
                        cnt_q      <= c_CNT_LOAD;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        if (is_write_q) begin
                            mem_q[idx_q] <= wdata_q;
                        end else begin
                            rdata_q <= mem_q[idx_q];
                        end
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - c_CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // DONE forces busywait low so the requester sees completion even with inputs held.
    always_comb begin
        MEM_BUSYWAIT = 1'b0;
        case (state_q)
            ST_IDLE: MEM_BUSYWAIT = w_req_any;
            ST_BUSY: MEM_BUSYWAIT = 1'b1;
            ST_DONE: MEM_BUSYWAIT = 1'b0;
            default: MEM_BUSYWAIT = 1'b0;
        endcase
    end

    assign MEM_READDATA = rdata_q;
    assign PROTOCOL_ERR = perr_q;

endmodule
`default_nettype wire
